// File: rtl/magnitude_peak_detector.sv
// Peak search over one frame of squared-magnitude bins.
// Reports the strongest in-range bin one cycle after end of frame.
module magnitude_peak_detector #(
    parameter int          N_BINS    = 1024,
    parameter int          BIN_W     = 10,
    parameter int          MIN_BIN   = 2,
    parameter int          MAX_BIN   = 511,
    parameter logic [31:0] THRESHOLD = 32'h0001_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mag_in,
    input  logic             mag_valid,
    input  logic             mag_sop,
    input  logic             mag_eop,
    output logic             peak_valid,
    output logic [BIN_W-1:0] peak_bin,
    output logic [31:0]      peak_mag,
    output logic             note_present,
    output logic             frame_error
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [BIN_W-1:0] LAST = BIN_W'(N_BINS - 1);
    localparam logic [BIN_W-1:0] LO   = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] HI   = BIN_W'(MAX_BIN);

    state_t           state, state_n;
    logic [BIN_W-1:0] cnt, cnt_n;
    logic [BIN_W-1:0] max_bin, max_bin_n;
    logic [31:0]      max_mag, max_mag_n;
    logic [BIN_W-1:0] bin, base_bin, pb_n;
    logic [31:0]      base_mag, pm_n;
    logic             start, eval, fin;
    logic             pv_n, fe_n, np_n;

    // Next-state, running-max update and report generation
    always_comb begin
        state_n   = (state == REPORT) ? IDLE : state;
        cnt_n     = cnt;
        max_bin_n = max_bin;
        max_mag_n = max_mag;
        pb_n      = peak_bin;
        pm_n      = peak_mag;
        np_n      = note_present;
        pv_n      = 1'b0;
        fe_n      = 1'b0;
        start     = 1'b0;
        eval      = 1'b0;
        fin       = 1'b0;
        bin       = cnt + 1'b1;
        base_bin  = max_bin;
        base_mag  = max_mag;

        if (mag_valid) begin
            unique case (state)
                IDLE, REPORT: begin
                    if (mag_sop)      start = 1'b1;
                    else if (mag_eop) fe_n  = 1'b1;
                end
                SCAN: begin
                    if (mag_sop) begin
                        // New frame before the old one ended
                        fe_n  = 1'b1;
                        start = 1'b1;
                    end else if (cnt == LAST) begin
                        // Frame longer than N_BINS
                        fe_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        eval  = 1'b1;
                        cnt_n = cnt + 1'b1;
                        fin   = mag_eop;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (start) begin
            cnt_n    = '0;
            bin      = '0;
            base_bin = LO;
            base_mag = '0;
            eval     = 1'b1;
            fin      = mag_eop;
            state_n  = SCAN;
        end

        if (eval) begin
            max_bin_n = base_bin;
            max_mag_n = base_mag;
            if (bin >= LO && bin <= HI && mag_in > base_mag) begin
                max_bin_n = bin;
                max_mag_n = mag_in;
            end
        end

        if (fin) begin
            state_n = REPORT;
            pv_n    = 1'b1;
            pb_n    = max_bin_n;
            pm_n    = max_mag_n;
            np_n    = (max_mag_n >= THRESHOLD);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            max_bin      <= '0;
            max_mag      <= '0;
            peak_valid   <= 1'b0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            note_present <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            max_bin      <= max_bin_n;
            max_mag      <= max_mag_n;
            peak_valid   <= pv_n;
            peak_bin     <= pb_n;
            peak_mag     <= pm_n;
            note_present <= np_n;
            frame_error  <= fe_n;
        end
    end

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Randomized bench for magnitude_peak_detector against a
// frame-level peak search model.
module tb_magnitude_peak_detector;

    localparam int          NB   = 1024;
    localparam int          BW   = 10;
    localparam int          MINB = 2;
    localparam int          MAXB = 511;
    localparam logic [31:0] THR  = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   mag_in = '0;
    logic          mag_valid = 1'b0;
    logic          mag_sop = 1'b0;
    logic          mag_eop = 1'b0;
    logic          peak_valid;
    logic [BW-1:0] peak_bin;
    logic [31:0]   peak_mag;
    logic          note_present;
    logic          frame_error;

    magnitude_peak_detector #(
        .N_BINS(NB), .BIN_W(BW), .MIN_BIN(MINB),
        .MAX_BIN(MAXB), .THRESHOLD(THR)
    ) dut (
        .clk(clk), .reset(reset), .mag_in(mag_in),
        .mag_valid(mag_valid), .mag_sop(mag_sop), .mag_eop(mag_eop),
        .peak_valid(peak_valid), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .note_present(note_present),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int pv_cnt = 0, fe_cnt = 0, pv_cyc = -1, fe_cyc = -1;
    int eop_cyc = 0, sop_cyc = 0, last_cyc = 0;
    int n_pass = 0, n_tot = 0;

    logic [31:0]   fr[$];
    logic [BW-1:0] exp_bin;
    logic [31:0]   exp_mag;
    logic          exp_np;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (peak_valid === 1'b1) begin
            pv_cnt++;
            pv_cyc = cyc;
        end
        if (frame_error === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
    end

    // Reference: maximum over in-range bins, first index wins ties
    task automatic calc();
        exp_mag = '0;
        exp_bin = BW'(MINB);
        for (int b = MINB; b <= MAXB && b < fr.size(); b++)
            if (fr[b] > exp_mag) begin
                exp_mag = fr[b];
                exp_bin = BW'(b);
            end
        exp_np = (exp_mag >= THR);
    endtask

    task automatic send(input logic [31:0] m, input logic s, input logic e);
        @(negedge clk);
        mag_valid = 1'b1;
        mag_in    = m;
        mag_sop   = s;
        mag_eop   = e;
        last_cyc  = cyc;
        if (e) eop_cyc = cyc;
        if (s) sop_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mag_valid = 1'b0;
            mag_in    = $urandom;
            mag_sop   = 1'($urandom);
            mag_eop   = 1'($urandom);
        end
    endtask

    task automatic run_frame(input int gap, input int tail);
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i], i == 0, i == fr.size() - 1);
            if (gap == 1) idle(1);
            else if (gap == 2 && $urandom_range(3) == 0)
                idle($urandom_range(1, 3));
        end
        idle(tail);
    endtask

    task automatic rand_frame(input int len);
        fr.delete();
        for (int i = 0; i < len; i++)
            fr.push_back(32'($urandom_range(0, 15)) << 14);
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            mag_valid = 1'b1;
            mag_sop   = 1'b1;
            mag_eop   = 1'b1;
            mag_in    = $urandom;
        end
        idle(1);
        reset = 1'b0;
        idle(2);
        n_tot++;
        if ({peak_valid, peak_bin, peak_mag, note_present, frame_error} !== '0)
            $display("FAIL reset_outputs got %0d/%0d/%h/%0d/%0d want all 0",
                     peak_valid, peak_bin, peak_mag, note_present, frame_error);
        else n_pass++;
        n_tot++;
        if (pv_cnt + fe_cnt !== 0)
            $display("FAIL reset_pulses got %0d want 0", pv_cnt + fe_cnt);
        else n_pass++;
    endtask

    task automatic test_ramp();
        int pv0 = pv_cnt, fe0 = fe_cnt;
        fr.delete();
        for (int i = 0; i < NB; i++) fr.push_back(32'(i));
        fr[100] = 32'h0002_0000;
        calc();
        run_frame(0, 4);
        n_tot++;
        if (pv_cnt - pv0 !== 1 || fe_cnt - fe0 !== 0 || pv_cyc !== eop_cyc + 1)
            $display("FAIL ramp_timing got pv=%0d fe=%0d lat=%0d want 1 0 1",
                     pv_cnt - pv0, fe_cnt - fe0, pv_cyc - eop_cyc);
        else n_pass++;
        n_tot++;
        if (peak_bin !== exp_bin || peak_mag !== exp_mag || note_present !== 1'b1
            || exp_bin !== BW'(100))
            $display("FAIL ramp_result got %0d/%h/%0d want 100/00020000/1",
                     peak_bin, peak_mag, note_present);
        else n_pass++;
    endtask

    task automatic test_tie();
        int pv0 = pv_cnt;
        fr.delete();
        for (int i = 0; i < NB; i++) fr.push_back('0);
        fr[0] = '1;
        fr[1] = '1;
        fr[37] = 32'h0000_5000;
        fr[200] = 32'h0000_5000;
        calc();
        run_frame(0, 3);
        n_tot++;
        if (pv_cnt - pv0 !== 1 || peak_bin !== BW'(37) || peak_mag !== 32'h5000
            || note_present !== 1'b0)
            $display("FAIL tie_result got %0d/%h/%0d pv=%0d want 37/00005000/0 pv=1",
                     peak_bin, peak_mag, note_present, pv_cnt - pv0);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int pv0;
        rand_frame(NB);
        calc();
        for (int g = 1; g <= 2; g++) begin
            pv0 = pv_cnt;
            run_frame(g, 3);
            n_tot++;
            if (pv_cnt - pv0 !== 1 || pv_cyc !== eop_cyc + 1 || peak_bin !== exp_bin
                || peak_mag !== exp_mag || note_present !== exp_np)
                $display("FAIL gaps_%0d got %0d/%h/%0d pv=%0d lat=%0d want %0d/%h/%0d 1 1",
                         g, peak_bin, peak_mag, note_present, pv_cnt - pv0,
                         pv_cyc - eop_cyc, exp_bin, exp_mag, exp_np);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        int pv0 = pv_cnt, fe0 = fe_cnt;
        for (int i = 0; i < 300; i++)
            send(32'h00FF_0000, i == 0, 1'b0);
        rand_frame(NB);
        calc();
        run_frame(0, 3);
        n_tot++;
        if (fe_cnt - fe0 !== 1 || fe_cyc !== sop_cyc + 1)
            $display("FAIL restart_error got n=%0d lat=%0d want 1 1",
                     fe_cnt - fe0, fe_cyc - sop_cyc);
        else n_pass++;
        n_tot++;
        if (pv_cnt - pv0 !== 1 || peak_bin !== exp_bin || peak_mag !== exp_mag
            || note_present !== exp_np)
            $display("FAIL restart_result got %0d/%h/%0d pv=%0d want %0d/%h/%0d 1",
                     peak_bin, peak_mag, note_present, pv_cnt - pv0,
                     exp_bin, exp_mag, exp_np);
        else n_pass++;
    endtask

    task automatic test_errors();
        int pv0 = pv_cnt, fe0 = fe_cnt;
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(2);
        n_tot++;
        if (fe_cnt - fe0 !== 0 || pv_cnt - pv0 !== 0)
            $display("FAIL stray_ignored got fe=%0d pv=%0d want 0 0",
                     fe_cnt - fe0, pv_cnt - pv0);
        else n_pass++;
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        idle(3);
        n_tot++;
        if (fe_cnt - fe0 !== 1 || fe_cyc !== last_cyc + 1 || pv_cnt - pv0 !== 0)
            $display("FAIL eop_idle got fe=%0d lat=%0d pv=%0d want 1 1 0",
                     fe_cnt - fe0, fe_cyc - last_cyc, pv_cnt - pv0);
        else n_pass++;
        fe0 = fe_cnt;
        for (int i = 0; i < NB + 1; i++)
            send(32'hFFFF_0000, i == 0, 1'b0);
        idle(3);
        n_tot++;
        if (fe_cnt - fe0 !== 1 || fe_cyc !== last_cyc + 1 || pv_cnt - pv0 !== 0)
            $display("FAIL overflow got fe=%0d lat=%0d pv=%0d want 1 1 0",
                     fe_cnt - fe0, fe_cyc - last_cyc, pv_cnt - pv0);
        else n_pass++;
        n_tot++;
        if (peak_bin !== exp_bin || peak_mag !== exp_mag || note_present !== exp_np)
            $display("FAIL hold got %0d/%h/%0d want %0d/%h/%0d",
                     peak_bin, peak_mag, note_present, exp_bin, exp_mag, exp_np);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pv0 = pv_cnt, fe0 = fe_cnt;
        rand_frame(NB);
        for (int i = 0; i < 500; i++) send(fr[i], i == 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        mag_valid = 1'b1;
        mag_sop = 1'b0;
        mag_eop = 1'b1;
        mag_in = fr[500];
        idle(1);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        n_tot++;
        if ({peak_valid, peak_bin, peak_mag, note_present, frame_error} !== '0
            || pv_cnt - pv0 !== 0 || fe_cnt - fe0 !== 0)
            $display("FAIL midreset got %0d/%h/%0d pv=%0d fe=%0d want 0/0/0 0 0",
                     peak_bin, peak_mag, note_present, pv_cnt - pv0, fe_cnt - fe0);
        else n_pass++;
        calc();
        run_frame(2, 3);
        n_tot++;
        if (pv_cnt - pv0 !== 1 || fe_cnt - fe0 !== 0 || peak_bin !== exp_bin
            || peak_mag !== exp_mag || note_present !== exp_np)
            $display("FAIL midreset_clean got %0d/%h/%0d pv=%0d want %0d/%h/%0d 1",
                     peak_bin, peak_mag, note_present, pv_cnt - pv0,
                     exp_bin, exp_mag, exp_np);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pv0 = pv_cnt, fe0 = fe_cnt;
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(32'h0003_0000);
        run_frame(0, 0);
        rand_frame(30);
        calc();
        run_frame(0, 3);
        n_tot++;
        if (pv_cnt - pv0 !== 2 || fe_cnt - fe0 !== 0 || pv_cyc !== eop_cyc + 1)
            $display("FAIL b2b_pulses got pv=%0d fe=%0d lat=%0d want 2 0 1",
                     pv_cnt - pv0, fe_cnt - fe0, pv_cyc - eop_cyc);
        else n_pass++;
        n_tot++;
        if (peak_bin !== exp_bin || peak_mag !== exp_mag || note_present !== exp_np)
            $display("FAIL b2b_result got %0d/%h/%0d want %0d/%h/%0d",
                     peak_bin, peak_mag, note_present, exp_bin, exp_mag, exp_np);
        else n_pass++;
    endtask

    task automatic test_random();
        int pv0;
        for (int k = 0; k < 6; k++) begin
            pv0 = pv_cnt;
            rand_frame(k == 0 ? 1 : k == 1 ? 3 : $urandom_range(4, NB));
            calc();
            run_frame(2, 3);
            n_tot++;
            if (pv_cnt - pv0 !== 1 || pv_cyc !== eop_cyc + 1 || peak_bin !== exp_bin
                || peak_mag !== exp_mag || note_present !== exp_np)
                $display("FAIL random_%0d len=%0d got %0d/%h/%0d pv=%0d want %0d/%h/%0d 1",
                         k, fr.size(), peak_bin, peak_mag, note_present,
                         pv_cnt - pv0, exp_bin, exp_mag, exp_np);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_tie();
        test_gaps();
        test_restart();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
